gcmd_queue: RTL and testbench
=============================

# gcmd_queue

Command queue and pacer between the CPU bus and the G10k graphics unit. Buffers 24-bit graphics commands written by the CPU and re-issues them on G10k's `in`/`start` pair as single-cycle strobes with a guaranteed minimum gap, so the clearer, text buffer and controllers always finish one command before the next arrives. CPU-inserted fence markers stall issue until the next frame-start pulse (G10k `irq`), which lets software batch scene updates into vertical blanking.

## Interface
- `DEPTH`, 16: queue entries; power of two, 2..64.
- `GAP`, 4: idle cycles forced between consecutive `ostart` pulses; 1..255.
- `clk`  in  1  system clock (same clock as G10k `clk`).
- `rst`  in  1  reset: asynchronous, active-low.
- `in`  in  24  command word from CPU.
- `start`  in  1  push `in` as a data entry (1-cycle strobe).
- `fence`  in  1  push a fence marker (1-cycle strobe).
- `frame`  in  1  frame-start pulse, connected to G10k `irq`.
- `clr_ovf`  in  1  clears the `ovf` flag.
- `out`  out  24  command word to G10k `in`.
- `ostart`  out  1  1-cycle strobe to G10k `start`.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `level`  out  log2(DEPTH)+1  current entry count.
- `ovf`  out  1  sticky: a push was dropped.

## Operation
- Storage: circular buffer of DEPTH entries, each 25 bits {is_fence, data[23:0]}. Fence entries carry data = 0. Read/write pointers wrap modulo DEPTH; count register gives `level`/`full`/`empty`.
- Push: `start` high -> write {0,`in`}. `fence` high, `start` low -> write {1,24'h0}. Both high -> data entry written, fence dropped, `ovf` set.
- Push while `full` (count at start of cycle) -> entry dropped, `ovf` set, queue unchanged, even if a pop occurs in the same cycle.
- Push and pop in the same cycle on a non-full queue -> count unchanged, both take effect.
- `ovf`: set on any drop; cleared by `clr_ovf`; set wins when both occur in the same cycle.
- Issue FSM, states IDLE, GAP, WAIT_FRAME:
  - IDLE, empty: stay.
  - IDLE, head is data: pop; register `out` <= data, `ostart` <= 1; load gap counter with GAP; go GAP.
  - IDLE, head is fence: pop; `ostart` stays 0; go WAIT_FRAME.
  - GAP: `ostart` <= 0; decrement the counter each cycle; go IDLE in the cycle the counter reaches 0.
  - WAIT_FRAME: go IDLE on the first cycle `frame` is sampled high. `frame` is sampled only while the registered state is WAIT_FRAME. A pulse coincident with the fence pop, or arriving in IDLE or GAP, is ignored.
- `out` holds the last issued word between strobes.
- Consecutive fences each consume one separate `frame` pulse.

## Timing
- Reset values: `out`=0, `ostart`=0, `full`=0, `empty`=1, `level`=0, `ovf`=0. State IDLE, pointers 0. Contents are don't-care.
- Reset asserted mid-operation flushes the queue and aborts GAP/WAIT_FRAME immediately. No further `ostart` until new pushes arrive after release.
- Latency, empty queue in IDLE: `start` sampled at edge k -> entry visible at k -> pop at edge k+1 -> `ostart` high for exactly the cycle between edges k+1 and k+2, with `out` valid from edge k+1.
- Back-to-back data entries: `ostart` rising edges are exactly GAP+2 clocks apart (1 strobe cycle, GAP gap cycles, 1 IDLE pop cycle).
- Fence release: `frame` sampled at edge f in WAIT_FRAME -> IDLE at f -> next data entry gives `ostart` high in the cycle after edge f+1.
- `full`, `empty`, `level` are registered and update at the edge that applies the push/pop.
- No combinational path from any input to any output.

## Test plan
- Reset/idle: hold `rst`=0, then release with no pushes -> `out`=0, `ostart`=0, `empty`=1, `level`=0 for 100 cycles.
- Pacing (GAP=4): push 0x000101, 0x000202, 0x000303 on consecutive cycles -> three 1-cycle `ostart` pulses, 6 clocks apart, with `out`=0x000101/0x000202/0x000303. The first pulse occurs 2 edges after the first `start`.
- Fence: push 0x0A0001, fence, 0x0A0002; pulse `frame` 50 cycles later -> 0x0A0001 issues immediately. 0x0A0002 issues only in the cycle after `frame`+1. A `frame` pulse coincident with the fence pop is ignored.
- Overflow (DEPTH=16): 17 consecutive pushes with the head fenced -> `full`=1, `level`=16, `ovf`=1; the 17th word never appears on `out`. `clr_ovf` -> `ovf`=0. `clr_ovf` together with another dropped push -> `ovf` stays 1.
- Wrap-around: 40 mixed pushes/pops with pointer wrap -> issue order exactly matches push order. A simultaneous `start`+`fence` issues the data word, drops the fence and sets `ovf`.
- Reset mid-GAP and mid-WAIT_FRAME with 5 entries queued -> all outputs return to reset values immediately. No `ostart` for 50 cycles after release.

Source files
------------

// File: rtl/gcmd_queue_if.sv
// Bus bundle between the CPU-side command source and the G10k command queue.
// The master side writes commands and fences; the slave side (the queue)
// issues paced strobes and reports its fill state.
interface gcmd_queue_if #(
    parameter int DEPTH = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [23:0]      in;
    logic             start;
    logic             fence;
    logic             frame;
    logic             clr_ovf;
    logic [23:0]      out;
    logic             ostart;
    logic             full;
    logic             empty;
    logic [LVL_W-1:0] level;
    logic             ovf;

    modport master (
        output in, start, fence, frame, clr_ovf,
        input  out, ostart, full, empty, level, ovf
    );

    modport slave (
        input  in, start, fence, frame, clr_ovf,
        output out, ostart, full, empty, level, ovf
    );
endinterface

// File: rtl/gcmd_queue.sv
// Command queue and pacer for the G10k graphics unit.
// Buffers CPU commands and fence markers in a circular buffer and re-issues
// data words as single-cycle strobes separated by at least GAP idle cycles.
// A fence stalls issue until the next frame-start pulse.
module gcmd_queue #(
    parameter int DEPTH = 16,
    parameter int GAP   = 4
) (
    input logic         clk,
    input logic         rst,
    gcmd_queue_if.slave bus
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [7:0]       GAP_LOAD = 8'(GAP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_WAIT_FRAME
    } state_e;

    typedef struct packed {
        logic        is_fence;
        logic [23:0] data;
    } entry_t;

    entry_t           mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_e           state_q, state_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic [23:0]      out_q, out_d;
    logic             ostart_q, ostart_d;
    logic             ovf_q, ovf_d;

    logic             full_w;
    logic             empty_w;
    logic             push_req;
    logic             push_ok;
    logic             drop;
    logic             pop;
    entry_t           push_entry;
    entry_t           head;

    assign full_w  = (count_q == FULL_CNT);
    assign empty_w = (count_q == '0);
    assign head    = mem[rd_ptr_q];

    // Push decode: what gets written, and whether anything is dropped.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        push_entry          = '0;
        push_req            = bus.start | bus.fence;
        push_ok             = push_req & ~full_w;
        drop                = (push_req & full_w) | (bus.start & bus.fence);
        push_entry.is_fence = ~bus.start;
        push_entry.data     = bus.start ? bus.in : 24'h0;
    end

    // Issue FSM: pops the head, strobes data words, paces and waits on fences.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        out_d     = out_q;
        ostart_d  = 1'b0;
        pop       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty_w) begin
                    pop = 1'b1;
                    if (head.is_fence) begin
                        state_d = ST_WAIT_FRAME;
                    end else begin
                        out_d     = head.data;
                        ostart_d  = 1'b1;
                        gap_cnt_d = GAP_LOAD;
                        state_d   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                // The strobe cycle plus GAP quiet cycles elapse before IDLE.
                if (gap_cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            ST_WAIT_FRAME: begin
                if (bus.frame) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pointer, occupancy and sticky-overflow next-state.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before the edge, independent of block order.
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            out_q     <= '0;
            ostart_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            out_q     <= out_d;
            ostart_q  <= ostart_d;
            ovf_q     <= ovf_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers and
        // count define which entries are valid, so stale contents are harmless.
        if (push_ok) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

    assign bus.out    = out_q;
    assign bus.ostart = ostart_q;
    assign bus.full   = full_w;
    assign bus.empty  = empty_w;
    assign bus.level  = count_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_gcmd_queue.sv
// Scoreboard bench for gcmd_queue (DEPTH=16, GAP=4). Stimulus pushes the
// expected issue words into a queue; a negedge monitor pops and compares
// each word the DUT strobes out and timestamps every strobe.
module tb_gcmd_queue;
    localparam int DEPTH = 16;
    localparam int GAP   = 4;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_err;

    logic [23:0] exp_q[$];
    int          ost_times[$];

    gcmd_queue_if #(.DEPTH(DEPTH)) bus ();

    gcmd_queue #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int ost_at(input int i);
        return (ost_times.size() > i) ? ost_times[i] : -1;
    endfunction

    // Advance to just after the next rising edge; cyc then names that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out"},    32'(bus.out),    32'h0);
        check({tag, "_ostart"}, 32'(bus.ostart), 32'h0);
        check({tag, "_full"},   32'(bus.full),   32'h0);
        check({tag, "_empty"},  32'(bus.empty),  32'h1);
        check({tag, "_level"},  32'(bus.level),  32'h0);
        check({tag, "_ovf"},    32'(bus.ovf),    32'h0);
    endtask

    // Monitor: every strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (rst && bus.ostart) begin
            ost_times.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ostart: got out=0x%0h, required no strobe (cycle %0d)", bus.out, cyc);
            end else begin
                check("issued_word", 32'(bus.out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int e;
        int d;
        n_cmp       = 0;
        n_err       = 0;
        cyc         = 0;
        rst         = 1'b1;
        bus.in      = '0;
        bus.start   = 1'b0;
        bus.fence   = 1'b0;
        bus.frame   = 1'b0;
        bus.clr_ovf = 1'b0;

        // Reset and idle
        #2 rst = 1'b0;
        repeat (3) step();
        check_reset_outputs("in_reset");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            repeat (10) step();
            check("idle_ostart", 32'(bus.ostart), 32'h0);
            check("idle_level",  32'(bus.level),  32'h0);
        end
        check_reset_outputs("idle_100");
        check("idle_no_strobes", 32'(ost_times.size()), 32'd0);

        // Pacing: three back-to-back words
        ost_times.delete();
        step();
        e = cyc;
        bus.start = 1'b1;
        bus.in = 24'h000101; exp_q.push_back(24'h000101); step();
        bus.in = 24'h000202; exp_q.push_back(24'h000202); step();
        bus.in = 24'h000303; exp_q.push_back(24'h000303); step();
        bus.start = 1'b0;
        check("pace_level_after_push", 32'(bus.level), 32'd2);
        repeat (25) step();
        check("pace_count",   32'(ost_times.size()), 32'd3);
        check("pace_first",   32'(ost_at(0)), 32'(e + 2));
        check("pace_second",  32'(ost_at(1)), 32'(e + 2 + GAP + 2));
        check("pace_third",   32'(ost_at(2)), 32'(e + 2 + 2 * (GAP + 2)));
        check("pace_out_hold", 32'(bus.out), 32'h000303);
        check("pace_empty",    32'(bus.empty), 32'h1);

        // Fence: early frame at the fence pop is ignored
        ost_times.delete();
        step();
        e = cyc;
        bus.start = 1'b1; bus.in = 24'h0A0001; exp_q.push_back(24'h0A0001); step();
        bus.start = 1'b0; bus.fence = 1'b1; step();
        bus.fence = 1'b0; bus.start = 1'b1; bus.in = 24'h0A0002; exp_q.push_back(24'h0A0002); step();
        bus.start = 1'b0;
        repeat (4) step();
        bus.frame = 1'b1; step();
        bus.frame = 1'b0;
        repeat (50) step();
        check("fence_first_issue", 32'(ost_at(0)), 32'(e + 2));
        check("fence_stalled",     32'(ost_times.size()), 32'd1);
        check("fence_level",       32'(bus.level), 32'd1);
        d = cyc;
        bus.frame = 1'b1; step();
        bus.frame = 1'b0;
        repeat (10) step();
        check("fence_release_count", 32'(ost_times.size()), 32'd2);
        check("fence_release_time",  32'(ost_at(1)), 32'(d + 2));

        // Overflow: stall behind a fence, then 17 data pushes
        ost_times.delete();
        bus.fence = 1'b1; step();
        bus.fence = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus.start = 1'b1;
            bus.in = 24'(32'h0B0000 + i);
            if (i < 16) exp_q.push_back(24'(32'h0B0000 + i));
            step();
        end
        bus.start = 1'b0;
        check("ovf_full",  32'(bus.full),  32'h1);
        check("ovf_level", 32'(bus.level), 32'd16);
        check("ovf_empty", 32'(bus.empty), 32'h0);
        check("ovf_set",   32'(bus.ovf),   32'h1);
        bus.clr_ovf = 1'b1; step();
        bus.clr_ovf = 1'b0;
        check("ovf_cleared", 32'(bus.ovf), 32'h0);
        bus.clr_ovf = 1'b1; bus.start = 1'b1; bus.in = 24'h000BAD; step();
        bus.clr_ovf = 1'b0; bus.start = 1'b0;
        check("ovf_set_wins",  32'(bus.ovf),   32'h1);
        check("ovf_level_kept", 32'(bus.level), 32'd16);
        bus.clr_ovf = 1'b1; step();
        bus.clr_ovf = 1'b0;
        check("ovf_cleared_again", 32'(bus.ovf), 32'h0);
        bus.frame = 1'b1; step();
        bus.frame = 1'b0;
        repeat (120) step();
        check("ovf_drain_count", 32'(ost_times.size()), 32'd16);
        check("ovf_drain_empty", 32'(bus.empty), 32'h1);

        // Wrap-around: 40 words in bursts, one with a simultaneous fence
        ost_times.delete();
        for (int i = 0; i < 40; i++) begin
            bus.start = 1'b1;
            bus.fence = (i == 20);
            bus.in = 24'(32'h100000 + i * 32'h111);
            exp_q.push_back(24'(32'h100000 + i * 32'h111));
            step();
            bus.start = 1'b0;
            bus.fence = 1'b0;
            if (i == 10) check("wrap_ovf_clear_before", 32'(bus.ovf), 32'h0);
            if (i == 20) check("wrap_dual_push_ovf",    32'(bus.ovf), 32'h1);
            if ((i % 4) == 3) repeat (24) step();
        end
        repeat (100) step();
        check("wrap_count", 32'(ost_times.size()), 32'd40);
        check("wrap_empty", 32'(bus.empty), 32'h1);
        check("wrap_ovf",   32'(bus.ovf),   32'h1);

        // Reset mid-GAP with 5 entries queued
        ost_times.delete();
        for (int i = 0; i < 6; i++) begin
            bus.start = 1'b1;
            bus.in = 24'(32'h0C0000 + i);
            exp_q.push_back(24'(32'h0C0000 + i));
            step();
        end
        bus.start = 1'b0;
        check("gap_level_before_reset", 32'(bus.level), 32'd5);
        rst = 1'b0;
        #1;
        exp_q.delete();
        check_reset_outputs("reset_mid_gap");
        repeat (3) step();
        rst = 1'b1;
        ost_times.delete();
        repeat (50) step();
        check("gap_no_strobe_after", 32'(ost_times.size()), 32'd0);
        check_reset_outputs("after_gap_reset");

        // Reset mid-WAIT_FRAME with 5 entries queued
        bus.fence = 1'b1; step();
        bus.fence = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.start = 1'b1;
            bus.in = 24'(32'h0D0000 + i);
            exp_q.push_back(24'(32'h0D0000 + i));
            step();
        end
        bus.start = 1'b0;
        check("wf_level_before_reset", 32'(bus.level), 32'd5);
        rst = 1'b0;
        #1;
        exp_q.delete();
        check_reset_outputs("reset_mid_wait");
        repeat (3) step();
        rst = 1'b1;
        ost_times.delete();
        bus.frame = 1'b1; step();
        bus.frame = 1'b0;
        repeat (50) step();
        check("wf_no_strobe_after", 32'(ost_times.size()), 32'd0);
        check_reset_outputs("after_wait_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
